spi_flash_read_seq: RTL and testbench
=====================================

SPI_FLASH_READ_SEQ -- requirements
Module: spi_flash_read_seq

Interface
Parameters:
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, giving the maximum number of bytes in flight between TX push and RX pop.
REQ-002 The block SHALL have parameter HDR_BYTES, fixed at 4 (one command byte plus 24-bit address), which is not user-overridable.

Ports:
REQ-003 clk  input  1  system clock; the single clock of the block.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cmd_valid_i  input  1  request to start a read transaction.
REQ-006 cmd_ready_o  output  1  block is idle and accepts a request.
REQ-007 cmd_op_i  input  8  SPI flash opcode, e.g. 0x03.
REQ-008 cmd_addr_i  input  24  flash byte address.
REQ-009 cmd_len_i  input  8  number of data bytes; 0 encodes 256.
REQ-010 abort_i  input  1  stop issuing bytes and terminate the transaction.
REQ-011 rd_data_o  output  8  returned flash data byte.
REQ-012 rd_valid_o  output  1  rd_data_o holds a valid byte.
REQ-013 rd_ready_i  input  1  consumer accepts rd_data_o.
REQ-014 done_o  output  1  one-cycle pulse at transaction end.
REQ-015 err_o  output  1  qualifies done_o; high when the transaction ended by abort.
REQ-016 tx_fifo_write_o  output  1  push tx_data_o into the SPI TX FIFO.
REQ-017 tx_data_o  output  8  byte pushed to the SPI TX FIFO.
REQ-018 tx_fifo_full_i  input  1  SPI TX FIFO is full.
REQ-019 rx_fifo_read_o  output  1  pop the SPI RX FIFO head.
REQ-020 rx_fifo_data_i  input  8  SPI RX FIFO head; valid whenever rx_fifo_empty_i is low.
REQ-021 rx_fifo_empty_i  input  1  SPI RX FIFO is empty.
REQ-022 spi_busy_i  input  1  SPI controller is shifting or holding chip-select.

Function
REQ-023 The FSM SHALL have states IDLE, RUN, DRAIN, FLUSH and DONE.
REQ-024 cmd_ready_o SHALL equal (state==IDLE); a request is accepted on cmd_valid_i & cmd_ready_o, at which point op, addr, len are latched, total=HDR_BYTES+len (9-bit len, 1..256), tx_cnt=rx_cnt=0, and the state goes to RUN.
REQ-025 The TX byte sequence SHALL be op, addr[23:16], addr[15:8], addr[7:0], then len bytes of 0xFF.
REQ-026 tx_fifo_write_o SHALL be asserted combinationally iff state==RUN & tx_cnt<total & !tx_fifo_full_i & (tx_cnt-rx_cnt)<FIFO_DEPTH & !abort_i; tx_cnt increments on each push.
REQ-027 rx_fifo_read_o SHALL be asserted iff state in {RUN,DRAIN} & !rx_fifo_empty_i & rx_cnt<tx_cnt & (rx_cnt<HDR_BYTES | !rd_valid_o | rd_ready_i); rx_cnt increments on each pop.
REQ-028 The first HDR_BYTES popped bytes SHALL be discarded, and each later popped byte SHALL load rd_data_o and set rd_valid_o on the next edge.
REQ-029 rd_valid_o SHALL clear on rd_valid_o & rd_ready_i unless reloaded in the same cycle, sustaining one byte per cycle.
REQ-030 In DRAIN during abort, popped data bytes SHALL be discarded and not presented on rd_data_o.
REQ-031 RUN SHALL transition to FLUSH when rx_cnt==total and rd_valid_o is clear or being accepted.
REQ-032 If abort_i is seen in RUN, the block SHALL set the abort flag and go to DRAIN, with no further pushes from that cycle.
REQ-033 DRAIN SHALL transition to FLUSH when rx_cnt==tx_cnt.
REQ-034 FLUSH SHALL wait for !spi_busy_i, then go to DONE.
REQ-035 DONE SHALL pulse done_o for one cycle with err_o equal to the abort flag, then return to IDLE.
REQ-036 Outside RUN/DRAIN, the counters SHALL hold their values.
REQ-037 abort_i SHALL be ignored in IDLE, FLUSH and DONE.
REQ-038 (tx_cnt-rx_cnt) SHALL never exceed FIFO_DEPTH, so the RX FIFO cannot overflow.
REQ-039 When the push and pop for the same count occur in one cycle, both counters SHALL update independently.
REQ-040 len=0 SHALL be treated as 256 data bytes (260 total).

Reset
REQ-041 On rst_n low, asynchronously: state=IDLE, tx_cnt=rx_cnt=0, abort flag=0, rd_valid_o=0, rd_data_o=0x00, done_o=0, err_o=0.
REQ-042 Under reset, tx_fifo_write_o and rx_fifo_read_o SHALL be 0 and cmd_ready_o SHALL be 1 once reset is released.
REQ-043 Reset mid-transaction SHALL discard all progress, with no done_o pulse.

Verification
REQ-044 op=0x03, addr=0x123456, len=2, loopback RX=TX -> TX 03,12,34,56,FF,FF; rd_data 0xFF,0xFF; done_o=1, err_o=0.
REQ-045 len=0 with a flash model returning incrementing data -> exactly 256 rd_valid handshakes, 260 pushes, done_o once.
REQ-046 len=20 with rd_ready_i held low after the first byte -> pushes stall at outstanding=8, no RX FIFO overflow; on release all 20 bytes arrive in order.
REQ-047 abort_i pulsed after the 6th push -> no 7th push, outstanding bytes popped, at most 2 data bytes forwarded, done_o=1, err_o=1.
REQ-048 tx_fifo_full_i toggled randomly with spi_busy_i high for 5 cycles after the last byte -> byte order preserved, done_o only after spi_busy_i falls.
REQ-049 rst_n asserted mid-RUN -> all outputs reach reset values immediately, and a new request is accepted cleanly afterwards.

Source files
------------

// File: rtl/spi_flash_read_seq.sv
// spi_flash_read_seq
// Sequences a single SPI flash read through an external SPI controller's
// TX/RX FIFOs. It pushes the command header (opcode plus 24-bit address)
// followed by dummy 0xFF bytes. It pops the same number of bytes back. The
// header echoes are dropped, and the data bytes are forwarded to a
// valid/ready consumer.
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   cmd_valid_i/cmd_ready_o request handshake (ready only when idle)
//   cmd_op_i/addr_i/len_i   opcode, flash byte address, data length (0 = 256)
//   abort_i                 stop pushing, drain outstanding bytes, end with err
//   rd_data_o/valid/ready   returned data bytes
//   done_o/err_o            one-cycle end pulse; err_o set if aborted
//   tx_fifo_*               push side of the SPI controller TX FIFO
//   rx_fifo_*               pop side of the SPI controller RX FIFO
//   spi_busy_i              controller still shifting / holding chip-select
//
// State table
//   state | meaning
//   IDLE  | waiting for a request, cmd_ready_o high
//   RUN   | pushing TX bytes and popping RX bytes
//   DRAIN | aborted: no pushes, pop and discard until all outstanding return
//   FLUSH | all bytes back, wait for the controller to go idle
//   DONE  | pulse done_o (err_o = abort flag), return to IDLE

module spi_flash_read_seq #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_op_i,
    input  logic [23:0] cmd_addr_i,
    input  logic [7:0]  cmd_len_i,
    input  logic        abort_i,
    output logic [7:0]  rd_data_o,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    output logic        done_o,
    output logic        err_o,
    output logic        tx_fifo_write_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_fifo_full_i,
    output logic        rx_fifo_read_o,
    input  logic [7:0]  rx_fifo_data_i,
    input  logic        rx_fifo_empty_i,
    input  logic        spi_busy_i
);

    localparam int HDR_BYTES = 4;
    localparam int CNT_W     = 9;   // total is at most 4 + 256 = 260

    localparam logic [CNT_W-1:0] HDR_CNT   = CNT_W'(HDR_BYTES);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [7:0]         op_q;
    logic [23:0]        addr_q;
    logic [CNT_W-1:0]   total_q;
    logic [CNT_W-1:0]   tx_cnt, rx_cnt;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   len_ext;
    logic               abort_q;
    logic               pop_ok;
    logic               accept;
    logic               pop_data;

    assign outstanding = tx_cnt - rx_cnt;
    assign len_ext     = (cmd_len_i == 8'd0) ? 9'd256 : {1'b0, cmd_len_i};
    assign accept      = cmd_valid_i & cmd_ready_o;
    // Only popped bytes past the header echo in RUN reach the consumer.
    // DRAIN is entered only on abort, so everything popped there is dropped.
    assign pop_data    = rx_fifo_read_o & (rx_cnt >= HDR_CNT) & (state == RUN);

    always_comb begin
        case (tx_cnt)
            9'd0:    tx_data_o = op_q;
            9'd1:    tx_data_o = addr_q[23:16];
            9'd2:    tx_data_o = addr_q[15:8];
            9'd3:    tx_data_o = addr_q[7:0];
            default: tx_data_o = 8'hFF;
        endcase
    end

    always_comb begin
        state_nxt       = state;
        cmd_ready_o     = (state == IDLE);
        tx_fifo_write_o = 1'b0;
        rx_fifo_read_o  = 1'b0;
        done_o          = 1'b0;
        err_o           = 1'b0;
        // Header echoes can always be popped; data bytes only when the output
        // register is free or being emptied this cycle.
        pop_ok = !rx_fifo_empty_i && (rx_cnt < tx_cnt) &&
                 ((rx_cnt < HDR_CNT) || !rd_valid_o || rd_ready_i);

        case (state)
            IDLE: begin
                if (cmd_valid_i) state_nxt = RUN;
            end
            RUN: begin
                // The outstanding limit keeps the RX FIFO from overflowing.
                tx_fifo_write_o = (tx_cnt < total_q) && !tx_fifo_full_i &&
                                  (outstanding < DEPTH_CNT) && !abort_i;
                rx_fifo_read_o  = pop_ok;
                if (abort_i)
                    state_nxt = DRAIN;
                else if ((rx_cnt == total_q) && (!rd_valid_o || rd_ready_i))
                    state_nxt = FLUSH;
            end
            DRAIN: begin
                rx_fifo_read_o = pop_ok;
                if (rx_cnt == tx_cnt) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (!spi_busy_i) state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                err_o     = abort_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 8'h00;
            addr_q  <= 24'h000000;
            total_q <= '0;
            tx_cnt  <= '0;
            rx_cnt  <= '0;
            abort_q <= 1'b0;
        end else if (accept) begin
            op_q    <= cmd_op_i;
            addr_q  <= cmd_addr_i;
            total_q <= HDR_CNT + len_ext;
            tx_cnt  <= '0;
            rx_cnt  <= '0;
            abort_q <= 1'b0;
        end else begin
            tx_cnt <= tx_cnt + CNT_W'(tx_fifo_write_o);
            rx_cnt <= rx_cnt + CNT_W'(rx_fifo_read_o);
            if ((state == RUN) && abort_i) abort_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_o  <= 8'h00;
            rd_valid_o <= 1'b0;
        end else if (pop_data) begin
            rd_data_o  <= rx_fifo_data_i;
            rd_valid_o <= 1'b1;
        end else if (rd_valid_o && rd_ready_i) begin
            rd_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Directed bench for spi_flash_read_seq. A small SPI controller model
// (TX push -> one-byte shift pipe -> RX queue) either loops TX bytes back or
// acts as a flash returning 0x00 for header slots and 0,1,2,... for data.
module tb_spi_flash_read_seq;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [7:0]  cmd_op_i = 8'h00;
    logic [23:0] cmd_addr_i = 24'h0;
    logic [7:0]  cmd_len_i = 8'h00;
    logic        abort_i = 1'b0;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    logic        rd_ready_i = 1'b1;
    logic        done_o;
    logic        err_o;
    logic        tx_fifo_write_o;
    logic [7:0]  tx_data_o;
    logic        tx_fifo_full_i = 1'b0;
    logic        rx_fifo_read_o;
    logic [7:0]  rx_fifo_data_i = 8'h00;
    logic        rx_fifo_empty_i = 1'b1;
    logic        spi_busy_i = 1'b0;

    spi_flash_read_seq #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_op_i        (cmd_op_i),
        .cmd_addr_i      (cmd_addr_i),
        .cmd_len_i       (cmd_len_i),
        .abort_i         (abort_i),
        .rd_data_o       (rd_data_o),
        .rd_valid_o      (rd_valid_o),
        .rd_ready_i      (rd_ready_i),
        .done_o          (done_o),
        .err_o           (err_o),
        .tx_fifo_write_o (tx_fifo_write_o),
        .tx_data_o       (tx_data_o),
        .tx_fifo_full_i  (tx_fifo_full_i),
        .rx_fifo_read_o  (rx_fifo_read_o),
        .rx_fifo_data_i  (rx_fifo_data_i),
        .rx_fifo_empty_i (rx_fifo_empty_i),
        .spi_busy_i      (spi_busy_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // controller / flash model state
    logic [7:0] rx_q[$];
    logic [7:0] pipe_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] rd_log[$];
    bit         flash_mode = 1'b0;
    bit         busy_force = 1'b0;
    bit         pend_push = 1'b0;
    bit         pend_pop  = 1'b0;
    logic [7:0] pend_byte = 8'h00;
    int         push_cnt = 0;
    int         pop_cnt = 0;
    int         done_cnt = 0;
    int         early_done = 0;
    int         model_err = 0;
    int         max_out = 0;
    logic       last_err = 1'b0;

    // Observe handshakes mid-cycle, where all combinational outputs are settled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_fifo_write_o) begin
                tx_log.push_back(tx_data_o);
                if (flash_mode)
                    pend_byte = (push_cnt < 4) ? 8'h00 : 8'(push_cnt - 4);
                else
                    pend_byte = tx_data_o;
                pend_push = 1'b1;
                push_cnt++;
            end
            if (rx_fifo_read_o) begin
                pend_pop = 1'b1;
                pop_cnt++;
            end
            if (rd_valid_o && rd_ready_i) rd_log.push_back(rd_data_o);
            if (done_o) begin
                done_cnt++;
                last_err = err_o;
                if (spi_busy_i) early_done++;
            end
            if (push_cnt - pop_cnt > max_out) max_out = push_cnt - pop_cnt;
        end
    end

    // Apply the observed pushes/pops just after the edge on which they took effect.
    always @(posedge clk) begin
        logic [7:0] tmp;
        #1;
        if (!rst_n) begin
            rx_q.delete();
            pipe_q.delete();
            pend_push = 1'b0;
            pend_pop  = 1'b0;
        end else begin
            if (pend_pop) begin
                if (rx_q.size() > 0) tmp = rx_q.pop_front();
                else model_err++;
            end
            if (pipe_q.size() > 0) rx_q.push_back(pipe_q.pop_front());
            if (pend_push) pipe_q.push_back(pend_byte);
            pend_push = 1'b0;
            pend_pop  = 1'b0;
            if (rx_q.size() > DEPTH) model_err++;
        end
        rx_fifo_empty_i = (rx_q.size() == 0);
        rx_fifo_data_i  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        spi_busy_i      = busy_force || (pipe_q.size() > 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        tx_log.delete();
        rd_log.delete();
        push_cnt = 0;
        pop_cnt = 0;
        done_cnt = 0;
        early_done = 0;
        max_out = 0;
        last_err = 1'b0;
    endtask

    task automatic issue(input logic [7:0] op, input logic [23:0] addr, input logic [7:0] len);
        cmd_op_i    = op;
        cmd_addr_i  = addr;
        cmd_len_i   = len;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        check_val({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (3) tick();
    endtask

    task automatic wait_pushes(input int target, input int budget);
        int n = 0;
        while (push_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check_val("push_wait", 32'(push_cnt >= target), 32'd1);
    endtask

    logic [7:0] exp_tx[6] = '{8'h03, 8'h12, 8'h34, 8'h56, 8'hFF, 8'hFF};

    initial begin
        int errs;
        int n;

        // reset state
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check_val("rst_tx_write", 32'(tx_fifo_write_o), 32'd0);
        check_val("rst_rx_read", 32'(rx_fifo_read_o), 32'd0);
        check_val("rst_rd_valid", 32'(rd_valid_o), 32'd0);
        check_val("rst_rd_data", 32'(rd_data_o), 32'h0);
        check_val("rst_done", 32'(done_o), 32'd0);
        check_val("rst_err", 32'(err_o), 32'd0);
        tick();

        // basic loopback read, len 2
        clear_logs();
        flash_mode = 1'b0;
        issue(8'h03, 24'h123456, 8'd2);
        wait_done("basic", 200);
        check_val("basic_push_cnt", 32'(tx_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < tx_log.size()) check_val($sformatf("basic_tx%0d", i), 32'(tx_log[i]), 32'(exp_tx[i]));
        check_val("basic_rd_cnt", 32'(rd_log.size()), 32'd2);
        for (int i = 0; i < rd_log.size() && i < 2; i++)
            check_val($sformatf("basic_rd%0d", i), 32'(rd_log[i]), 32'hFF);
        check_val("basic_done_cnt", 32'(done_cnt), 32'd1);
        check_val("basic_err", 32'(last_err), 32'd0);

        // len 0 means 256 data bytes
        clear_logs();
        flash_mode = 1'b1;
        issue(8'h0B, 24'hABCDEF, 8'd0);
        wait_done("len0", 3000);
        check_val("len0_pushes", 32'(push_cnt), 32'd260);
        check_val("len0_rd_cnt", 32'(rd_log.size()), 32'd256);
        errs = 0;
        for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] !== 8'(i)) errs++;
        check_val("len0_order_errs", 32'(errs), 32'd0);
        check_val("len0_done_cnt", 32'(done_cnt), 32'd1);
        check_val("len0_tx_op", 32'(tx_log.size() > 0 ? tx_log[0] : 8'h00), 32'h0B);
        check_val("len0_tx_a0", 32'(tx_log.size() > 3 ? tx_log[3] : 8'h00), 32'hEF);

        // consumer stalls after first byte: pushes must stop at DEPTH outstanding
        clear_logs();
        flash_mode = 1'b1;
        rd_ready_i = 1'b1;
        issue(8'h03, 24'h000100, 8'd20);
        n = 0;
        while (rd_log.size() < 1 && n < 200) begin tick(); n++; end
        rd_ready_i = 1'b0;
        repeat (40) tick();
        check_val("stall_max_out", 32'(max_out), 32'(DEPTH));
        check_val("stall_pushes_held", 32'(push_cnt < 24), 32'd1);
        check_val("stall_no_done", 32'(done_cnt), 32'd0);
        rd_ready_i = 1'b1;
        wait_done("stall", 500);
        check_val("stall_rd_cnt", 32'(rd_log.size()), 32'd20);
        errs = 0;
        for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] !== 8'(i)) errs++;
        check_val("stall_order_errs", 32'(errs), 32'd0);
        check_val("stall_max_out_final", 32'(max_out), 32'(DEPTH));

        // abort after the 6th push
        clear_logs();
        flash_mode = 1'b0;
        issue(8'h03, 24'h001000, 8'd20);
        wait_pushes(6, 200);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        wait_done("abort", 300);
        check_val("abort_pushes", 32'(push_cnt), 32'd6);
        check_val("abort_pops", 32'(pop_cnt), 32'd6);
        check_val("abort_fwd_le2", 32'(rd_log.size() <= 2), 32'd1);
        check_val("abort_done_cnt", 32'(done_cnt), 32'd1);
        check_val("abort_err", 32'(last_err), 32'd1);
        check_val("abort_idle_ready", 32'(cmd_ready_o), 32'd1);

        // TX FIFO full toggling, controller busy held past the last byte
        clear_logs();
        flash_mode = 1'b1;
        busy_force = 1'b1;
        issue(8'h03, 24'h7FFFFF, 8'd6);
        n = 0;
        while (rd_log.size() < 6 && n < 500) begin
            tx_fifo_full_i = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        tx_fifo_full_i = 1'b0;
        repeat (5) tick();
        check_val("busy_no_early_done", 32'(done_cnt), 32'd0);
        busy_force = 1'b0;
        wait_done("busy", 100);
        check_val("busy_early_done", 32'(early_done), 32'd0);
        check_val("busy_rd_cnt", 32'(rd_log.size()), 32'd6);
        errs = 0;
        for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] !== 8'(i)) errs++;
        check_val("busy_order_errs", 32'(errs), 32'd0);
        check_val("busy_tx_a2", 32'(tx_log.size() > 1 ? tx_log[1] : 8'h00), 32'h7F);
        check_val("busy_err", 32'(last_err), 32'd0);

        // reset mid-RUN, then a clean transaction
        clear_logs();
        flash_mode = 1'b1;
        issue(8'h03, 24'h000200, 8'd20);
        wait_pushes(5, 200);
        rst_n = 1'b0;
        #1;
        check_val("midrst_tx_write", 32'(tx_fifo_write_o), 32'd0);
        check_val("midrst_rx_read", 32'(rx_fifo_read_o), 32'd0);
        check_val("midrst_rd_valid", 32'(rd_valid_o), 32'd0);
        check_val("midrst_rd_data", 32'(rd_data_o), 32'h0);
        check_val("midrst_done", 32'(done_o), 32'd0);
        check_val("midrst_ready", 32'(cmd_ready_o), 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_val("midrst_no_done", 32'(done_cnt), 32'd0);
        clear_logs();
        flash_mode = 1'b0;
        issue(8'h03, 24'h123456, 8'd2);
        wait_done("after_rst", 200);
        check_val("after_rst_pushes", 32'(push_cnt), 32'd6);
        check_val("after_rst_rd_cnt", 32'(rd_log.size()), 32'd2);
        check_val("after_rst_rd0", 32'(rd_log.size() > 0 ? rd_log[0] : 8'h00), 32'hFF);
        check_val("after_rst_done_cnt", 32'(done_cnt), 32'd1);
        check_val("after_rst_err", 32'(last_err), 32'd0);

        check_val("model_errors", 32'(model_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
